// File: rtl/ysyx_23060208_isram_if.sv
// AR/R read channel between the IFU (master) and the instruction SRAM (slave).
interface ysyx_23060208_isram_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] isram_araddr;
    logic                  isram_arvalid;
    logic                  isram_arready;
    logic [DATA_WIDTH-1:0] isram_rdata;
    logic                  isram_rvalid;
    logic [1:0]            isram_rresp;
    logic                  isram_rready;

    modport master (
        output isram_araddr, isram_arvalid, isram_rready,
        input  isram_arready, isram_rdata, isram_rvalid, isram_rresp
    );

    modport slave (
        input  isram_araddr, isram_arvalid, isram_rready,
        output isram_arready, isram_rdata, isram_rvalid, isram_rresp
    );
endinterface

// File: rtl/ysyx_23060208_isram.sv
// Instruction SRAM slave for the IFU: single outstanding AR/R read with a
// preloadable word store and fixed or LFSR-driven response latency.
module ysyx_23060208_isram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_W     = 12,
    parameter logic [DATA_WIDTH-1:0] ADDR_BASE  = 32'h8000_0000,
    parameter int                    RAND_LAT   = 0,
    parameter int                    FIXED_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_23060208_isram_if.slave  bus,
    input  logic                  load_en,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);
    localparam int                    MEM_WORDS   = 1 << ADDR_W;
    localparam logic [DATA_WIDTH-1:0] MEM_BYTES   = DATA_WIDTH'(4 * MEM_WORDS);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [1:0]            RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_LAT, RESP} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  arready, arready_n;
    logic                  rvalid, rvalid_n;
    logic [DATA_WIDTH-1:0] rdata, rdata_n;
    logic [1:0]            rresp, rresp_n;
    logic [7:0]            lfsr;
    logic [3:0]            lat;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] dec_data;
    logic [1:0]            dec_resp;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    // Maximal-length x^8+x^6+x^5+x^4+1; a non-zero seed never reaches zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 8'hA5;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign lat = (RAND_LAT != 0) ? ({1'b0, lfsr[2:0]} + 4'd1) : 4'(FIXED_LAT);

    // Decode at the handshake; a same-edge preload is not yet visible in mem.
    always_comb begin
        offset   = bus.isram_araddr - ADDR_BASE;
        dec_resp = RESP_OKAY;
        dec_data = '0;
        if (bus.isram_araddr[1:0] != 2'b00) dec_resp = RESP_SLVERR;
        else if (offset >= MEM_BYTES)        dec_resp = RESP_DECERR;
        else                                 dec_data = mem[offset[ADDR_W+1:2]];
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        arready_n = arready;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        case (state)
            IDLE: begin
                arready_n = 1'b1;
                if (bus.isram_arvalid && arready) begin
                    arready_n = 1'b0;
                    cnt_n     = lat;
                    rdata_n   = dec_data;
                    rresp_n   = dec_resp;
                    state_n   = WAIT_LAT;
                end
            end
            WAIT_LAT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    rvalid_n = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP: begin
                if (rvalid && bus.isram_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
        end
    end

    assign bus.isram_arready = arready;
    assign bus.isram_rvalid  = rvalid;
    assign bus.isram_rdata   = rdata;
    assign bus.isram_rresp   = rresp;
endmodule

// File: tb/tb_ysyx_23060208_isram.sv
// Bench for ysyx_23060208_isram: three instances (L=1, L=3, random latency)
// driven from one directed sequence and checked against a word-array model.
module tb_ysyx_23060208_isram;
    localparam int          DW   = 32;
    localparam int          AW   = 12;
    localparam int          NW   = 4096;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] araddr    [3];
    logic          arvalid   [3];
    logic          rready    [3];
    logic          load_en   [3];
    logic [AW-1:0] load_addr [3];
    logic [DW-1:0] load_data [3];
    logic          arready   [3];
    logic          rvalid    [3];
    logic [DW-1:0] rdata     [3];
    logic [1:0]    rresp     [3];

    ysyx_23060208_isram_if #(.DATA_WIDTH(DW)) bus0 ();
    ysyx_23060208_isram_if #(.DATA_WIDTH(DW)) bus1 ();
    ysyx_23060208_isram_if #(.DATA_WIDTH(DW)) bus2 ();

    assign bus0.isram_araddr  = araddr[0];
    assign bus0.isram_arvalid = arvalid[0];
    assign bus0.isram_rready  = rready[0];
    assign arready[0] = bus0.isram_arready;
    assign rvalid[0]  = bus0.isram_rvalid;
    assign rdata[0]   = bus0.isram_rdata;
    assign rresp[0]   = bus0.isram_rresp;

    assign bus1.isram_araddr  = araddr[1];
    assign bus1.isram_arvalid = arvalid[1];
    assign bus1.isram_rready  = rready[1];
    assign arready[1] = bus1.isram_arready;
    assign rvalid[1]  = bus1.isram_rvalid;
    assign rdata[1]   = bus1.isram_rdata;
    assign rresp[1]   = bus1.isram_rresp;

    assign bus2.isram_araddr  = araddr[2];
    assign bus2.isram_arvalid = arvalid[2];
    assign bus2.isram_rready  = rready[2];
    assign arready[2] = bus2.isram_arready;
    assign rvalid[2]  = bus2.isram_rvalid;
    assign rdata[2]   = bus2.isram_rdata;
    assign rresp[2]   = bus2.isram_rresp;

    ysyx_23060208_isram #(.DATA_WIDTH(DW), .ADDR_W(AW), .ADDR_BASE(BASE), .RAND_LAT(0), .FIXED_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .bus(bus0),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]));
    ysyx_23060208_isram #(.DATA_WIDTH(DW), .ADDR_W(AW), .ADDR_BASE(BASE), .RAND_LAT(0), .FIXED_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .bus(bus1),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]));
    ysyx_23060208_isram #(.DATA_WIDTH(DW), .ADDR_W(AW), .ADDR_BASE(BASE), .RAND_LAT(1), .FIXED_LAT(1)) u_rnd (
        .clk(clk), .rst(rst), .bus(bus2),
        .load_en(load_en[2]), .load_addr(load_addr[2]), .load_data(load_data[2]));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [3][NW];
    logic [7:0]  m_lfsr;

    // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, new bit enters at the bottom.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int   taps [4] = '{8, 6, 5, 4};
        logic fb       = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]-1];
        return {s[6:0], fb};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic void expect_rsp(input int sel, input logic [31:0] a,
                                       output logic [1:0] resp, output logic [31:0] data);
        logic [31:0] off;
        off  = a - BASE;
        resp = 2'b00;
        data = 32'h0;
        if (a % 32'd4 != 32'd0)          resp = 2'b10;
        else if (off >= 32'(4 * NW))     resp = 2'b11;
        else                             data = mdl[sel][int'(off / 32'd4)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input int sel, input int idx, input logic [31:0] d);
        load_en[sel]   = 1'b1;
        load_addr[sel] = AW'(idx);
        load_data[sel] = d;
        @(negedge clk);
        load_en[sel]   = 1'b0;
        mdl[sel][idx]  = d;
    endtask

    // rmode: 0 rready always high, 1 random rready, 2 rready low for 10 cycles
    task automatic fetch(input int sel, input logic [31:0] addr, input int rmode,
                         input bit do_load, input int la, input logic [31:0] ld);
        int          waited, lat, exp_lat, k;
        bit          done;
        logic [1:0]  e_resp, h_resp;
        logic [31:0] e_data, h_data;
        waited = 0;
        while (arready[sel] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ar_open", 32'(arready[sel]), 32'd1);
        expect_rsp(sel, addr, e_resp, e_data);
        exp_lat = (sel == 2) ? int'(m_lfsr[2:0]) + 1 : ((sel == 0) ? 1 : 3);
        araddr[sel]  = addr;
        arvalid[sel] = 1'b1;
        if (do_load) begin
            load_en[sel]   = 1'b1;
            load_addr[sel] = AW'(la);
            load_data[sel] = ld;
        end
        @(negedge clk);
        arvalid[sel] = 1'b0;
        load_en[sel] = 1'b0;
        if (do_load) mdl[sel][la] = ld;
        lat = 0;
        while (rvalid[sel] !== 1'b1 && lat < 20) begin
            chk("ar_closed_wait", 32'(arready[sel]), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("excl", 32'(arready[sel] & rvalid[sel]), 32'd0);
        chk("rresp", 32'(rresp[sel]), 32'(e_resp));
        chk("rdata", rdata[sel], e_data);
        h_data = rdata[sel];
        h_resp = rresp[sel];
        done = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            case (rmode)
                0:       rready[sel] = 1'b1;
                1:       rready[sel] = 1'($urandom_range(0, 1));
                default: rready[sel] = (k >= 10);
            endcase
            @(negedge clk);
            if (rready[sel]) begin
                chk("r_done_rvalid", 32'(rvalid[sel]), 32'd0);
                chk("r_done_arready", 32'(arready[sel]), 32'd1);
                done = 1'b1;
            end else begin
                chk("hold_rvalid", 32'(rvalid[sel]), 32'd1);
                chk("hold_arready", 32'(arready[sel]), 32'd0);
                chk("hold_rdata", rdata[sel], h_data);
                chk("hold_rresp", 32'(rresp[sel]), 32'(h_resp));
            end
            k++;
        end
        rready[sel] = 1'b0;
        chk("r_complete", 32'(done), 32'd1);
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
            load_en[i] = 1'b0; load_addr[i] = '0; load_data[i] = '0;
        end
        #3 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_arready", 32'(arready[i]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[i]), 32'd0);
            chk("rst_rresp", 32'(rresp[i]), 32'd0);
            chk("rst_rdata", rdata[i], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("rel_arready", 32'(arready[i]), 32'd1);

        load(0, 0, 32'h0000_0413);
        load(0, 1, 32'h0010_0093);
        load(0, 5, 32'h1234_5678);
        load(1, 2, 32'hCAFE_F00D);
        for (int i = 0; i < 64; i++) load(2, i, $urandom);

        fetch(0, 32'h8000_0000, 0, 1'b0, 0, 32'h0);
        fetch(0, 32'h8000_0004, 0, 1'b0, 0, 32'h0);
        fetch(0, 32'h8000_0002, 0, 1'b0, 0, 32'h0);
        fetch(0, 32'h8000_4000, 0, 1'b0, 0, 32'h0);
        fetch(0, 32'h7FFF_FFFC, 0, 1'b0, 0, 32'h0);
        fetch(0, 32'h8000_3FFC + 32'h4, 0, 1'b0, 0, 32'h0);

        fetch(0, 32'h8000_0014, 0, 1'b1, 5, 32'hDEAD_BEEF);
        fetch(0, 32'h8000_0014, 0, 1'b0, 0, 32'h0);
        chk("collision_model", mdl[0][5], 32'hDEAD_BEEF);

        fetch(1, 32'h8000_0008, 2, 1'b0, 0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                1:       a = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 1000));
                2:       a = BASE - 32'(4 * (1 + $urandom_range(0, 1000)));
                default: a = BASE + 32'(4 * $urandom_range(0, 63));
            endcase
            fetch(2, a, 1, 1'b0, 0, 32'h0);
        end

        araddr[1]  = BASE + 32'h8;
        arvalid[1] = 1'b1;
        @(negedge clk);
        arvalid[1] = 1'b0;
        @(negedge clk);
        chk("mid_wait_rvalid", 32'(rvalid[1]), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid[1]), 32'd0);
        chk("mid_rst_arready", 32'(arready[1]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_arready", 32'(arready[1]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("no_stale_rvalid", 32'(rvalid[1]), 32'd0);
            @(negedge clk);
        end
        fetch(1, 32'h8000_0008, 0, 1'b0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
